prco_uart_loader: RTL and testbench
===================================

Name: prco_uart_loader

Overview:
- Program loader for prco_core: receives a framed program image over UART, writes 16-bit words into the core's instruction memory, and holds the core in reset until a frame with a valid checksum has loaded.
- Writer side of the imem interface that prco_core reads, and the boot path for the clk50 board build.

Parameters:
- CLK_HZ, 50000000, clk50 frequency in Hz.
- BAUD, 115200, UART bit rate. Bit period DIV = CLK_HZ/BAUD (integer truncation; 434 at defaults).
- ADDR_W, 8, imem word-address width.

Ports:
- clk50  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, 8N1, LSB first, idle high.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  16  word data.
- core_rst_n  out  1  active-low reset to prco_core.
- busy  out  1  high while a frame is in progress.
- err  out  1  sticky error flag; cleared only by the next valid sync byte.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, err=0. The FSM is in SYNC and the receiver is idle.
- Byte receiver:
  - uart_rx passes through a 2-flop synchroniser; the receiver acts on the synchronised signal.
  - A falling edge starts a byte. Sample the start bit at DIV/2; if it reads high, treat it as a glitch and return to idle without error.
  - Then take 8 data samples, each DIV after the previous, then the stop bit.
  - Stop bit = 1: pulse an internal byte_valid for one cycle with the byte.
  - Stop bit = 0: framing error. Set err, drop the byte, FSM to SYNC.
  - The receiver is ready for the next start edge immediately after the stop sample.
- Frame format: 0xA5, LEN (word count N), N words each sent hi byte then lo byte, then CSUM. CSUM = XOR of all 2N data bytes, starting from 0x00.
- FSM states and transitions (each on byte_valid):
  - SYNC: 0xA5 -> LEN; clear err, set busy, drive core_rst_n=0, set imem_addr=0, clear the running checksum. Any other byte is ignored.
  - LEN: store N. N=0 -> CSUM; otherwise -> HI.
  - HI: latch the hi byte -> LO.
  - LO: imem_wdata={hi,lo}; imem_we=1 on the next cycle, exactly 1 cycle. imem_addr increments the cycle after the strobe and wraps modulo 2^ADDR_W. After word N -> CSUM, otherwise -> HI.
  - CSUM: byte matches the running XOR -> DONE; mismatch -> set err, -> SYNC with core_rst_n held 0.
  - DONE: core_rst_n=1 and busy=0 on the cycle after entry. core_rst_n stays 1 until another 0xA5 arrives, which re-enters LEN and drops core_rst_n to 0 on the next cycle.
- Checksum update: the running XOR updates in the same cycle as byte_valid in HI/LO.
- Word address: with N > 2^ADDR_W, writes wrap and overwrite from address 0. This is legal and not an error.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). A partially received byte is discarded.
- Latency: imem_we asserts 1 cycle after the byte_valid of the lo byte. core_rst_n releases 1 cycle after the byte_valid of CSUM.

Optional Feature:
- PRCO_LOADER_TIMEOUT_EN defined:
  - A 24-bit idle counter resets on every byte_valid and runs while busy=1.
  - If it reaches 16*DIV*10 cycles (16 byte times), set err, FSM -> SYNC, busy=0, core_rst_n stays 0.
- Not defined: no counter; a stalled frame waits indefinitely.

Test Plan:
- Frame A5 02 12 34 AB CD 40 (CSUM = 12^34^AB^CD) at 115200 baud -> writes 0x1234@0 and 0xABCD@1, each imem_we exactly 1 cycle; core_rst_n rises 1 cycle after CSUM; err=0.
- Same frame with CSUM 0x41 -> no core_rst_n release; err=1; busy=0; a following correct frame clears err and releases the core.
- Bytes 00 FF 5A, then a valid A5 01 00 07 07 -> leading bytes ignored; single write 0x0007@0; core released.
- Stop bit forced to 0 on the second data byte -> err=1, FSM in SYNC, no imem_we issued for that word.
- Assert rst_n low in the middle of a lo byte, then release it and send a valid frame -> outputs at reset values during reset; the new frame loads from address 0 correctly.
- ADDR_W=1 build, N=3 words 0001 0002 0003 -> address sequence 0,1,0; final memory {0003,0002}. With PRCO_LOADER_TIMEOUT_EN, stopping after the LEN byte -> err=1 after the timeout, busy=0.

Source files
------------

// File: rtl/prco_uart_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prco_uart_loader                                           |
// | Description : UART program loader for prco_core. Receives a framed      |
// |               image (A5, LEN, N hi/lo word pairs, XOR checksum), writes  |
// |               16-bit words into instruction memory and holds the core in |
// |               reset until a frame with a valid checksum has loaded.      |
// |               Optional: PRCO_LOADER_TIMEOUT_EN adds an idle timeout that  |
// |               aborts a stalled frame after 16 byte times.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prco_uart_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 8
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              err
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_SYNC, S_LEN, S_HI, S_LO, S_CSUM, S_DONE} state_t;

  // receiver state
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid, frame_err;

  // frame state
  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d, wcnt_q, wcnt_d, hi_q, hi_d, csum_q, csum_d;
  logic             we_q, we_d, core_q, core_d, busy_q, busy_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             timeout_hit;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver state register
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Receiver next state: mid-start check, 8 LSB-first data samples, stop sample
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = R_START;
      end
      R_START: begin
        if (rx_cnt_q == HALF_C) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // a start bit that is high again at mid-bit was a glitch
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == DIV_C) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == DIV_C) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          byte_valid = rx_s2_q;
          frame_err  = !rx_s2_q;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

`ifdef PRCO_LOADER_TIMEOUT_EN
  localparam logic [23:0] TO_LIMIT = 24'(16 * DIV * 10);
  logic [23:0] idle_q, idle_d;

  // Idle counter runs only inside a frame and restarts on each received byte
  always_comb begin
    idle_d = (byte_valid || !busy_q) ? 24'd0 : idle_q + 24'd1;
  end

  // Idle counter register
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign timeout_hit = busy_q && (idle_q == TO_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame state and output registers
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SYNC;
      len_q   <= '0;
      wcnt_q  <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      core_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      core_q  <= core_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Frame parser: all outputs are registered, so each takes effect the cycle after byte_valid
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    // address advances the cycle after each write strobe, wrapping naturally
    addr_d  = we_q ? addr_q + ADDR_W'(1) : addr_q;
    wdata_d = wdata_q;
    core_d  = core_q;
    busy_d  = busy_q;
    err_d   = err_q;
    if (frame_err) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = S_SYNC;
    end else if (timeout_hit) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      core_d  = 1'b0;
      state_d = S_SYNC;
    end else if (byte_valid) begin
      case (state_q)
        S_SYNC, S_DONE: begin
          if (rx_shift_q == 8'hA5) begin
            state_d = S_LEN;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            core_d  = 1'b0;
            addr_d  = '0;
            csum_d  = '0;
          end
        end
        S_LEN: begin
          len_d   = rx_shift_q;
          wcnt_d  = '0;
          state_d = (rx_shift_q == 8'd0) ? S_CSUM : S_HI;
        end
        S_HI: begin
          hi_d    = rx_shift_q;
          csum_d  = csum_q ^ rx_shift_q;
          state_d = S_LO;
        end
        S_LO: begin
          wdata_d = {hi_q, rx_shift_q};
          we_d    = 1'b1;
          csum_d  = csum_q ^ rx_shift_q;
          wcnt_d  = wcnt_q + 8'd1;
          state_d = (wcnt_q == len_q - 8'd1) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          busy_d = 1'b0;
          if (rx_shift_q == csum_q) begin
            state_d = S_DONE;
            core_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = core_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prco_uart_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_prco_uart_loader                                        |
// | Description : Self-checking bench for prco_uart_loader. Two instances:   |
// |               ADDR_W=8 for frame handling, ADDR_W=1 for address wrap.    |
// |               Timeout scenario runs when PRCO_LOADER_TIMEOUT_EN is set.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_prco_uart_loader;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;   // 16 clocks per bit

  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_a  = 1'b1;
  logic        rx_b  = 1'b1;

  logic        we_a, core_a, busy_a, err_a;
  logic [7:0]  addr_a;
  logic [15:0] wdata_a;
  logic        we_b, core_b, busy_b, err_b;
  logic [0:0]  addr_b;
  logic [15:0] wdata_b;

  always #5 clk50 = ~clk50;

  prco_uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(8)) u_dut_a (
    .clk50(clk50), .rst_n(rst_n), .uart_rx(rx_a),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .core_rst_n(core_a), .busy(busy_a), .err(err_a)
  );

  prco_uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(1)) u_dut_b (
    .clk50(clk50), .rst_n(rst_n), .uart_rx(rx_b),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .core_rst_n(core_b), .busy(busy_b), .err(err_b)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          t_start  = 0;
  int          rise_cyc = 0;
  logic [23:0] exp_a[$];          // {addr, data} expected writes
  logic [23:0] exp_b[$];
  logic [23:0] ea, eb;
  logic [7:0]  tx_q[$];
  logic [15:0] mem_b [0:1];
  logic        we_a_prev = 1'b0, we_b_prev = 1'b0, core_a_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  always @(posedge clk50) cyc <= cyc + 1;

  // Write monitor / scoreboard for both instances
  always @(negedge clk50) begin
    if (we_a_prev) check("we_a_1cyc", {31'd0, we_a}, 32'd0);
    if (we_a) begin
      if (exp_a.size() == 0) check("unexp_we_a", 32'd1, 32'd0);
      else begin
        ea = exp_a.pop_front();
        check("addr_a", {24'd0, addr_a}, {24'd0, ea[23:16]});
        check("data_a", {16'd0, wdata_a}, {16'd0, ea[15:0]});
      end
    end
    if (we_b_prev) check("we_b_1cyc", {31'd0, we_b}, 32'd0);
    if (we_b) begin
      mem_b[addr_b] = wdata_b;
      if (exp_b.size() == 0) check("unexp_we_b", 32'd1, 32'd0);
      else begin
        eb = exp_b.pop_front();
        check("addr_b", {31'd0, addr_b}, {24'd0, eb[23:16]});
        check("data_b", {16'd0, wdata_b}, {16'd0, eb[15:0]});
      end
    end
    if (core_a && !core_a_prev) rise_cyc = cyc;
    we_a_prev   = we_a;
    we_b_prev   = we_b;
    core_a_prev = core_a;
  end

  task automatic send_byte(input bit to_b, input logic [7:0] b, input bit bad_stop);
    logic [9:0] fr;
    fr = {~bad_stop, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      if (to_b) rx_b = fr[i];
      else      rx_a = fr[i];
      repeat (DIV) @(negedge clk50);
    end
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (DIV) @(negedge clk50);
  endtask

  task automatic send_q(input bit to_b);
    for (int i = 0; i < tx_q.size(); i++) send_byte(to_b, tx_q[i], 1'b0);
    tx_q.delete();
  endtask

  // release must follow the checksum stop sample (9.5 bit times) by sync + 1 cycle
  task automatic check_release_latency(input string tag);
    int lat;
    lat = rise_cyc - t_start;
    check(tag, {31'd0, (lat >= 9*DIV + DIV/2) && (lat <= 9*DIV + DIV/2 + 8)}, 32'd1);
  endtask

  initial begin
    repeat (4) @(negedge clk50);
    // reset values
    check("rst_we",    {31'd0, we_a},   32'd0);
    check("rst_addr",  {24'd0, addr_a}, 32'd0);
    check("rst_wdata", {16'd0, wdata_a}, 32'd0);
    check("rst_core",  {31'd0, core_a}, 32'd0);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_err",   {31'd0, err_a},  32'd0);
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk50);

    // good frame
    exp_a.push_back({8'd0, 16'h1234});
    exp_a.push_back({8'd1, 16'hABCD});
    tx_q = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_q(1'b0);
    check("f1_core", {31'd0, core_a}, 32'd1);
    check("f1_err",  {31'd0, err_a},  32'd0);
    check("f1_busy", {31'd0, busy_a}, 32'd0);
    check("f1_qempty", exp_a.size(), 32'd0);
    check_release_latency("f1_rel_lat");

    // bad checksum, then a good frame clears err
    exp_a.push_back({8'd0, 16'h1234});
    exp_a.push_back({8'd1, 16'hABCD});
    send_byte(1'b0, 8'hA5, 1'b0);
    check("f2_sync_busy", {31'd0, busy_a}, 32'd1);
    check("f2_sync_core", {31'd0, core_a}, 32'd0);
    tx_q = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_q(1'b0);
    check("f2_core", {31'd0, core_a}, 32'd0);
    check("f2_err",  {31'd0, err_a},  32'd1);
    check("f2_busy", {31'd0, busy_a}, 32'd0);
    exp_a.push_back({8'd0, 16'h1234});
    exp_a.push_back({8'd1, 16'hABCD});
    send_byte(1'b0, 8'hA5, 1'b0);
    check("f3_err_clr", {31'd0, err_a}, 32'd0);
    tx_q = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_q(1'b0);
    check("f3_core", {31'd0, core_a}, 32'd1);
    check("f3_err",  {31'd0, err_a},  32'd0);
    check_release_latency("f3_rel_lat");

    // leading junk bytes are ignored
    tx_q = {8'h00, 8'hFF, 8'h5A};
    send_q(1'b0);
    check("f4_junk_busy", {31'd0, busy_a}, 32'd0);
    check("f4_junk_core", {31'd0, core_a}, 32'd1);
    exp_a.push_back({8'd0, 16'h0007});
    tx_q = {8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
    send_q(1'b0);
    check("f4_core", {31'd0, core_a}, 32'd1);
    check("f4_err",  {31'd0, err_a},  32'd0);
    check("f4_qempty", exp_a.size(), 32'd0);

    // framing error on the second data byte: no write, back to SYNC
    tx_q = {8'hA5, 8'h02, 8'h12};
    send_q(1'b0);
    send_byte(1'b0, 8'h34, 1'b1);
    check("f5_err",  {31'd0, err_a},  32'd1);
    check("f5_busy", {31'd0, busy_a}, 32'd0);
    check("f5_core", {31'd0, core_a}, 32'd0);
    tx_q = {8'hAB, 8'hCD, 8'h40};
    send_q(1'b0);
    check("f5_sync_busy", {31'd0, busy_a}, 32'd0);
    check("f5_sync_core", {31'd0, core_a}, 32'd0);
    check("f5_sync_err",  {31'd0, err_a},  32'd1);

    // reset in the middle of a lo byte
    exp_a.push_back({8'd0, 16'h1122});
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_q(1'b0);
    rx_a = 1'b0;
    repeat (3 * DIV) @(negedge clk50);
    #2 rst_n = 1'b0;
    #1;
    check("mr_we",    {31'd0, we_a},    32'd0);
    check("mr_addr",  {24'd0, addr_a},  32'd0);
    check("mr_wdata", {16'd0, wdata_a}, 32'd0);
    check("mr_core",  {31'd0, core_a},  32'd0);
    check("mr_busy",  {31'd0, busy_a},  32'd0);
    check("mr_err",   {31'd0, err_a},   32'd0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk50);
    exp_a.push_back({8'd0, 16'h1234});
    exp_a.push_back({8'd1, 16'hABCD});
    tx_q = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_q(1'b0);
    check("f6_core", {31'd0, core_a}, 32'd1);
    check("f6_err",  {31'd0, err_a},  32'd0);
    check("f6_qempty", exp_a.size(), 32'd0);

    // ADDR_W=1 instance: three words wrap 0,1,0
    exp_b.push_back({8'd0, 16'h0001});
    exp_b.push_back({8'd1, 16'h0002});
    exp_b.push_back({8'd0, 16'h0003});
    tx_q = {8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    send_q(1'b1);
    check("wr_mem0", {16'd0, mem_b[0]}, 32'h0003);
    check("wr_mem1", {16'd0, mem_b[1]}, 32'h0002);
    check("wr_core", {31'd0, core_b}, 32'd1);
    check("wr_err",  {31'd0, err_b},  32'd0);
    check("wr_qempty", exp_b.size(), 32'd0);

`ifdef PRCO_LOADER_TIMEOUT_EN
    // stall after LEN: aborts after 16 byte times of silence
    tx_q = {8'hA5, 8'h02};
    send_q(1'b0);
    repeat (16 * DIV * 10 / 2) @(negedge clk50);
    check("to_busy_early", {31'd0, busy_a}, 32'd1);
    check("to_err_early",  {31'd0, err_a},  32'd0);
    repeat (16 * DIV * 10) @(negedge clk50);
    check("to_err",  {31'd0, err_a},  32'd1);
    check("to_busy", {31'd0, busy_a}, 32'd0);
    check("to_core", {31'd0, core_a}, 32'd0);
`endif

    repeat (4) @(negedge clk50);
    check("end_qa", exp_a.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
